// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, oversampled at the system clock.
// Pairs with uart_tx through a shared clk_per_bit value.
module uart_rx #(
    parameter int clk_per_bit = 10417
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_serial_data,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_valid,
    output logic       o_rx_frame_err,
    output logic       o_rx_busy
);

    localparam int CW = (clk_per_bit > 1) ? $clog2(clk_per_bit) : 1;
    localparam logic [CW-1:0] HALF = CW'((clk_per_bit - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(clk_per_bit - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE,
        S_BREAK
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic [2:0]      bit_idx, bit_idx_nxt;
    logic [7:0]      shift, shift_nxt;
    logic [7:0]      byte_nxt;
    logic            valid_nxt;
    logic            ferr_nxt;
    logic            rx_meta;
    logic            rx_s;

    // Synchroniser flops reset to the idle line level so reset never looks like a start bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx_serial_data;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= S_IDLE;
            count          <= '0;
            bit_idx        <= '0;
            shift          <= '0;
            o_rx_byte      <= '0;
            o_rx_valid     <= 1'b0;
            o_rx_frame_err <= 1'b0;
        end else begin
            state          <= state_nxt;
            count          <= count_nxt;
            bit_idx        <= bit_idx_nxt;
            shift          <= shift_nxt;
            o_rx_byte      <= byte_nxt;
            o_rx_valid     <= valid_nxt;
            o_rx_frame_err <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        byte_nxt    = o_rx_byte;
        valid_nxt   = 1'b0;
        ferr_nxt    = 1'b0;

        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_nxt = S_START;
                    count_nxt = '0;
                end
            end
            // Re-check the line at mid start bit; a high level here was a glitch.
            S_START: begin
                if (count == HALF) begin
                    count_nxt = '0;
                    if (!rx_s) begin
                        state_nxt   = S_DATA;
                        bit_idx_nxt = '0;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            S_DATA: begin
                if (count == LAST) begin
                    count_nxt          = '0;
                    shift_nxt[bit_idx] = rx_s;
                    if (bit_idx == 3'd7) begin
                        state_nxt = S_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            S_STOP: begin
                if (count == LAST) begin
                    count_nxt = '0;
                    if (rx_s) begin
                        byte_nxt  = shift;
                        valid_nxt = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            // A line held low after a bad stop bit must not retrigger as a new start.
            S_BREAK: begin
                if (rx_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_rx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit with a byte scoreboard
// and edge-time recording of the valid, frame-error and busy outputs.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_rx_serial_data = 1'b1;
    logic [7:0] o_rx_byte;
    logic       o_rx_valid;
    logic       o_rx_frame_err;
    logic       o_rx_busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int  valid_cnt = 0;
    int  ferr_cnt = 0;
    int  last_valid_cyc = -1;
    int  last_ferr_cyc = -1;
    int  busy_rise = -1;
    int  busy_fall = -1;
    logic prev_busy = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_ferr = 1'b0;

    uart_rx #(.clk_per_bit(CPB)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_rx_serial_data (i_rx_serial_data),
        .o_rx_byte        (o_rx_byte),
        .o_rx_valid       (o_rx_valid),
        .o_rx_frame_err   (o_rx_frame_err),
        .o_rx_busy        (o_rx_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold the line at v for n clock edges, ending 1 time unit after an edge.
    task automatic driveBit(input logic v, input int n);
        i_rx_serial_data = v;
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input int cpb,
                                 input logic stop_val, input int gap_bits);
        if (stop_val) exp_q.push_back(data);
        driveBit(1'b0, cpb);
        for (int i = 0; i < 8; i++) driveBit(data[i], cpb);
        driveBit(stop_val, cpb);
        if (gap_bits > 0) driveBit(1'b1, gap_bits * cpb);
    endtask

    // Output monitor, sampled on the falling edge away from register updates.
    always @(negedge i_clk) begin
        logic [7:0] e;
        if (o_rx_valid) begin
            checkOutput("valid_pulse_width", {31'd0, prev_valid}, 32'd0);
            checkOutput("valid_ferr_exclusive", {31'd0, o_rx_frame_err}, 32'd0);
            checkOutput("scoreboard_nonempty", {31'd0, (exp_q.size() != 0)}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("rx_byte", {24'd0, o_rx_byte}, {24'd0, e});
            end
            valid_cnt++;
            last_valid_cyc = cyc;
        end
        if (o_rx_frame_err) begin
            checkOutput("ferr_pulse_width", {31'd0, prev_ferr}, 32'd0);
            ferr_cnt++;
            last_ferr_cyc = cyc;
        end
        if (o_rx_busy && !prev_busy) busy_rise = cyc;
        if (!o_rx_busy && prev_busy) busy_fall = cyc;
        prev_busy  = o_rx_busy;
        prev_valid = o_rx_valid;
        prev_ferr  = o_rx_frame_err;
    end

    initial begin
        int n;
        int vc;
        int fc;

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("reset_byte", {24'd0, o_rx_byte}, 32'd0);
        checkOutput("reset_valid", {31'd0, o_rx_valid}, 32'd0);
        checkOutput("reset_ferr", {31'd0, o_rx_frame_err}, 32'd0);
        checkOutput("reset_busy", {31'd0, o_rx_busy}, 32'd0);
        i_rst = 1'b0;
        driveBit(1'b1, 5);

        // Single frame 0xA5 with exact timing
        $display("[TB] frame 0xA5");
        n = cyc;
        applyStimulus(8'hA5, CPB, 1'b1, 1);
        driveBit(1'b1, 20);
        checkOutput("a5_valid_count", valid_cnt, 32'd1);
        checkOutput("a5_valid_cycle", last_valid_cyc, n + 155);
        checkOutput("a5_busy_rise", busy_rise, n + 3);
        checkOutput("a5_busy_fall", busy_fall, n + 156);
        checkOutput("a5_byte", {24'd0, o_rx_byte}, 32'h0000_00A5);
        checkOutput("a5_no_ferr", ferr_cnt, 32'd0);

        // Back-to-back frames
        $display("[TB] back-to-back 0x00 0xFF 0x3C");
        vc = valid_cnt;
        applyStimulus(8'h00, CPB, 1'b1, 0);
        applyStimulus(8'hFF, CPB, 1'b1, 0);
        applyStimulus(8'h3C, CPB, 1'b1, 0);
        driveBit(1'b1, 40);
        checkOutput("b2b_valid_count", valid_cnt, vc + 3);
        checkOutput("b2b_no_ferr", ferr_cnt, 32'd0);
        checkOutput("b2b_queue_empty", exp_q.size(), 32'd0);
        checkOutput("b2b_byte", {24'd0, o_rx_byte}, 32'h0000_003C);

        // Framing error followed by a held-low line
        $display("[TB] framing error 0x55");
        vc = valid_cnt;
        n = cyc;
        applyStimulus(8'h55, CPB, 1'b0, 0);
        driveBit(1'b0, 40);
        driveBit(1'b1, 60);
        checkOutput("ferr_count", ferr_cnt, 32'd1);
        checkOutput("ferr_cycle", last_ferr_cyc, n + 155);
        checkOutput("ferr_byte_held", {24'd0, o_rx_byte}, 32'h0000_003C);
        checkOutput("ferr_no_valid", valid_cnt, vc);
        checkOutput("ferr_busy_fall", busy_fall, n + 203);
        checkOutput("ferr_no_restart", busy_rise, n + 3);

        // Short low glitch on an idle line
        $display("[TB] glitch");
        vc = valid_cnt;
        fc = ferr_cnt;
        n = cyc;
        driveBit(1'b0, 3);
        driveBit(1'b1, 30);
        checkOutput("glitch_busy_rise", busy_rise, n + 3);
        checkOutput("glitch_busy_fall", busy_fall, n + 11);
        checkOutput("glitch_no_valid", valid_cnt, vc);
        checkOutput("glitch_no_ferr", ferr_cnt, fc);

        // Reset in the middle of the data bits of 0x81
        $display("[TB] reset mid-frame");
        vc = valid_cnt;
        driveBit(1'b0, CPB);
        driveBit(1'b1, CPB);
        driveBit(1'b0, CPB);
        driveBit(1'b0, 5);
        checkOutput("pre_reset_busy", {31'd0, o_rx_busy}, 32'd1);
        #3;
        i_rst = 1'b1;
        i_rx_serial_data = 1'b1;
        #1;
        checkOutput("midrst_byte", {24'd0, o_rx_byte}, 32'd0);
        checkOutput("midrst_valid", {31'd0, o_rx_valid}, 32'd0);
        checkOutput("midrst_ferr", {31'd0, o_rx_frame_err}, 32'd0);
        checkOutput("midrst_busy", {31'd0, o_rx_busy}, 32'd0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        driveBit(1'b1, 20);
        checkOutput("midrst_no_valid", valid_cnt, vc);
        applyStimulus(8'h42, CPB, 1'b1, 1);
        driveBit(1'b1, 20);
        checkOutput("post_rst_valid_count", valid_cnt, vc + 1);
        checkOutput("post_rst_byte", {24'd0, o_rx_byte}, 32'h0000_0042);
        checkOutput("post_rst_no_ferr", ferr_cnt, fc);

        // Baud skew on both sides of the nominal rate
        $display("[TB] baud skew 15 and 17");
        vc = valid_cnt;
        applyStimulus(8'hC3, 15, 1'b1, 2);
        checkOutput("skew15_byte", {24'd0, o_rx_byte}, 32'h0000_00C3);
        applyStimulus(8'h00, CPB, 1'b1, 1);
        applyStimulus(8'hC3, 17, 1'b1, 2);
        driveBit(1'b1, 20);
        checkOutput("skew_valid_count", valid_cnt, vc + 3);
        checkOutput("skew17_byte", {24'd0, o_rx_byte}, 32'h0000_00C3);
        checkOutput("skew_queue_empty", exp_q.size(), 32'd0);
        checkOutput("skew_no_ferr", ferr_cnt, fc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver, 8N1, LSB first, oversampling at the system clock. It is the receive-side counterpart of the team's `uart_tx` and shares its `clk_per_bit` baud convention, so one parameter value pairs a TX/RX link. It synchronises the asynchronous serial input, validates the start bit at mid-bit, and samples 8 data bits and 1 stop bit at bit centres. Each received byte is presented with a single-cycle valid strobe, and a bad stop bit raises a framing-error strobe.

## Interface
- `clk_per_bit`, default 10417: clock cycles per serial bit (100 MHz / 9600 baud); legal range ≥ 4.
- `i_clk` input, 1 bit: system clock; all logic uses its rising edge.
- `i_rst` input, 1 bit: reset, asynchronous and active-high.
- `i_rx_serial_data` input, 1 bit: serial line, idle high, asynchronous to `i_clk`.
- `o_rx_byte` output, 8 bits: last correctly framed byte; holds its value between frames.
- `o_rx_valid` output, 1 bit: 1-cycle pulse; `o_rx_byte` is new in the same cycle.
- `o_rx_frame_err` output, 1 bit: 1-cycle pulse; stop bit sampled low.
- `o_rx_busy` output, 1 bit: high whenever the FSM is not in IDLE.

## Operation
- Two-flop synchroniser on `i_rx_serial_data`. Both flops reset to 1. The FSM uses only the second flop output, `rx_s`.
- Let H = (clk_per_bit−1)/2 (integer division) and C = clk_per_bit.
- The counter resets to 0 and has width ceil(log2(C)). The bit index is 0..7.
- IDLE: when `rx_s`=0, go to START and set count=0. Otherwise stay in IDLE.
- START: increment count until count==H. On that edge:
  - `rx_s`=0: go to DATA with count=0, bit index=0.
  - `rx_s`=1: glitch; return to IDLE with no output pulse.
- DATA: increment count until count==C−1. On that edge:
  - shift `rx_s` into the shift register at position bit index (LSB first);
  - set count=0;
  - after bit index 7, go to STOP; otherwise increment the bit index.
- STOP: increment count until count==C−1. On that edge:
  - `rx_s`=1: load `o_rx_byte` from the shift register, pulse `o_rx_valid`, go to DONE.
  - `rx_s`=0: pulse `o_rx_frame_err`, leave `o_rx_byte` unchanged, go to BREAK.
- DONE: one cycle, then IDLE.
- BREAK: wait until `rx_s`=1, then go to IDLE. This prevents a held-low line from producing repeated false starts.
- An illegal state encoding goes to IDLE.
- Asynchronous reset, including mid-frame:
  - FSM to IDLE; count, bit index and shift register to 0;
  - `o_rx_byte`=0x00, `o_rx_valid`=0, `o_rx_frame_err`=0, `o_rx_busy`=0;
  - synchroniser flops to 1.
- A partially received frame is discarded and produces no pulse.

## Timing
- Pin-to-FSM latency: 2 cycles through the synchroniser.
- Let E0 be the rising edge at which IDLE sees `rx_s`=0. Relative to E0:
  - start check at E0+H+1;
  - data bit k (k=0..7) sampled at E0+H+1+(k+1)·C;
  - stop bit sampled at E0+H+1+9·C.
- `o_rx_valid` or `o_rx_frame_err` is registered on the stop-sample edge and is high for exactly one cycle.
- `o_rx_valid` and `o_rx_frame_err` are never high together.
- `o_rx_busy` rises on E0. It falls on the edge that returns the FSM to IDLE: E0+H+2+9·C for a good frame, E0+H+1 for a glitch, or the first `rx_s`=1 edge in BREAK.
- Back-to-back frames: a start bit whose `rx_s` falls during DONE is detected in the cycle after DONE. At most 2 cycles of slip accumulate per frame; this is within the half-bit margin.
- No backpressure. The consumer must capture `o_rx_byte` on `o_rx_valid`. `o_rx_byte` remains stable until the next valid frame.

## Test plan
- clk_per_bit=16, send 0xA5 at 16 clk/bit with a 1-bit idle gap. Required: `o_rx_byte`=0xA5, `o_rx_valid` high 1 cycle at E0+152, `o_rx_busy` high from E0 to E0+153.
- Back-to-back 0x00, 0xFF, 0x3C with no idle between frames. Required: three valid pulses in order, no framing error.
- 0x55 with the stop bit driven low, line then held low for 40 cycles and released high. Required:
  - `o_rx_frame_err` pulses once at E0+152;
  - `o_rx_byte` keeps its previous value;
  - FSM stays in BREAK until the line rises; no spurious start follows.
- 3-cycle low glitch on an idle line. Required: start rejected at E0+8, `o_rx_busy` low again at E0+8, no pulses.
- Assert `i_rst` mid-data of 0x81, release it, then send 0x42. Required:
  - outputs go to 0 immediately on reset;
  - no pulse for 0x81;
  - 0x42 is received correctly.
- Baud skew: 0xC3 sent at 15 and at 17 clk/bit with clk_per_bit=16. Required: both are received as 0xC3.
